// File: rtl/toggle_pattern_checker_pkg.sv
// Shared definitions for the toggle pattern checker.
// Holds the FSM state encoding and the default parameter values used by
// the top module and the bench.
package toggle_pattern_checker_pkg;

  // HUNT=0, LOCKED=1, SLIP=2. The encoding is visible on the debug state
  // output, so keep these values stable.
  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    LOCKED = 2'd1,
    SLIP   = 2'd2
  } state_t;

  localparam int LOCK_COUNT_DEF = 4;
  localparam int LOSS_COUNT_DEF = 2;
  localparam int ERR_W_DEF      = 16;

endpackage

// File: rtl/toggle_pattern_checker_if.sv
// Signal bundle between the toggle line source and the checker.
//   din       : sampled line, driven by the source side
//   clr_err   : one-cycle pulse that clears the error counter
//   locked    : checker is in LOCKED or SLIP
//   err_pulse : one-cycle strobe per counted error
//   err_count : saturating error count
// There is no valid/ready handshake: din is sampled on every rising edge,
// and clr_err is acted on in whichever cycle it is high.
interface toggle_pattern_checker_if #(
  parameter int ERR_W = 16
);
  logic             din;
  logic             clr_err;
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;

  modport master (
    output din,
    output clr_err,
    input  locked,
    input  err_pulse,
    input  err_count
  );

  modport slave (
    input  din,
    input  clr_err,
    output locked,
    output err_pulse,
    output err_count
  );
endinterface

// File: rtl/toggle_pattern_checker_sat_counter.sv
// sat_counter: W-bit up-counter that saturates at all-ones.
//   clk, rst : clock and asynchronous active-high reset
//   clr_i    : synchronous clear to zero
//   inc_i    : increment. When it coincides with clr_i the counter loads 1,
//              so the event that arrives with the clear is still counted.
//   count_o  : current count
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);
  localparam logic [W-1:0] MAX_V = '1;

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i) begin
      if (clr_i) begin
        count_d = W'(1);
      end else if (count_q != MAX_V) begin
        count_d = count_q + W'(1);
      end
    end else if (clr_i) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
endmodule

// File: rtl/toggle_pattern_checker.sv
// Receive-side checker for an alternating 0/1 line.
// The line is sampled every rising edge and each sample is compared with the
// previous one. After LOCK_COUNT consecutive toggles the checker locks. While
// locked, every missing toggle is counted as an error, and LOSS_COUNT
// consecutive misses drop lock.
//   clk, reset : clock and asynchronous active-high reset
//   bus        : slave side of toggle_pattern_checker_if (din, clr_err in;
//                locked, err_pulse, err_count out)
//   state_o    : current FSM state (HUNT/LOCKED/SLIP encoding from the package)
module toggle_pattern_checker
  import toggle_pattern_checker_pkg::*;
#(
  parameter int LOCK_COUNT = LOCK_COUNT_DEF,
  parameter int LOSS_COUNT = LOSS_COUNT_DEF,
  parameter int ERR_W      = ERR_W_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  toggle_pattern_checker_if.slave       bus,
  output logic [1:0]                    state_o
);
  // Sized so the counters can hold LOCK_COUNT / LOSS_COUNT themselves.
  localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W = $clog2(LOSS_COUNT + 1);
  localparam logic [RUN_W-1:0]  LOCK_V = RUN_W'(LOCK_COUNT);
  localparam logic [MISS_W-1:0] LOSS_V = MISS_W'(LOSS_COUNT);

  state_t            state_q, state_d;
  logic              prev_q;
  logic              prev_valid_q;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic              err_pulse_q;
  logic              count_err;
  logic              good, bad;
  logic [ERR_W-1:0]  err_count;

  // No comparison on the first edge after reset: prev holds nothing yet.
  assign good = prev_valid_q && (bus.din != prev_q);
  assign bad  = prev_valid_q && (bus.din == prev_q);

  // State and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= HUNT;
      prev_q       <= 1'b0;
      prev_valid_q <= 1'b0;
      run_q        <= '0;
      miss_q       <= '0;
    end else begin
      state_q      <= state_d;
      prev_q       <= bus.din;
      prev_valid_q <= 1'b1;
      run_q        <= run_d;
      miss_q       <= miss_d;
    end
  end

  // Next-state logic. count_err marks the edges where an error is counted.
  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    miss_d    = miss_q;
    count_err = 1'b0;
    case (state_q)
      HUNT: begin
        if (good) begin
          if (run_q + RUN_W'(1) == LOCK_V) begin
            state_d = LOCKED;
            run_d   = '0;
            miss_d  = '0;
          end else begin
            run_d = run_q + RUN_W'(1);
          end
        end else if (bad) begin
          run_d = '0;
        end
      end
      LOCKED: begin
        if (good) begin
          miss_d = '0;
        end else if (bad) begin
          count_err = 1'b1;
          if (LOSS_COUNT == 1) begin
            state_d = HUNT;
            run_d   = '0;
            miss_d  = '0;
          end else begin
            state_d = SLIP;
            miss_d  = MISS_W'(1);
          end
        end
      end
      SLIP: begin
        if (good) begin
          state_d = LOCKED;
          miss_d  = '0;
        end else if (bad) begin
          count_err = 1'b1;
          if (miss_q + MISS_W'(1) == LOSS_V) begin
            state_d = HUNT;
            run_d   = '0;
            miss_d  = '0;
          end else begin
            miss_d = miss_q + MISS_W'(1);
          end
        end
      end
      default: begin
        state_d = HUNT;
        run_d   = '0;
        miss_d  = '0;
      end
    endcase
  end

  // Output register: the error strobe lands on the same edge that made the
  // comparison, so outputs show that edge's result with no extra latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_pulse_q <= 1'b0;
    end else begin
      err_pulse_q <= count_err;
    end
  end

  sat_counter #(
    .W(ERR_W)
  ) u_err_cnt (
    .clk     (clk),
    .rst     (reset),
    .clr_i   (bus.clr_err),
    .inc_i   (count_err),
    .count_o (err_count)
  );

  // locked is decoded from the registered state, so it is itself registered.
  assign bus.locked    = (state_q != HUNT);
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_count = err_count;
  assign state_o       = state_q;
endmodule

// File: tb/tb_toggle_pattern_checker.sv
module tb_toggle_pattern_checker;
  import toggle_pattern_checker_pkg::*;

  localparam int LOCK_N = 4;
  localparam int LOSS_N = 2;
  localparam int EXP_W  = 22;

  // ---------------- clock / reset ----------------
  logic clk     = 1'b0;
  logic reset   = 1'b0;
  logic din     = 1'b0;
  logic clr_err = 1'b0;

  always #5 clk = ~clk;

  toggle_pattern_checker_if #(.ERR_W(16)) bus_a ();
  toggle_pattern_checker_if #(.ERR_W(2))  bus_b ();

  assign bus_a.din     = din;
  assign bus_a.clr_err = clr_err;
  assign bus_b.din     = din;
  assign bus_b.clr_err = clr_err;

  logic [1:0] state_a, state_b;

  toggle_pattern_checker #(.LOCK_COUNT(LOCK_N), .LOSS_COUNT(LOSS_N), .ERR_W(16)) dut_a (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus_a),
    .state_o (state_a)
  );

  toggle_pattern_checker #(.LOCK_COUNT(LOCK_N), .LOSS_COUNT(LOSS_N), .ERR_W(2)) dut_b (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus_b),
    .state_o (state_b)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [EXP_W-1:0] exp_q[$];

  // reference model of the checker behaviour
  logic [1:0]  m_state;
  logic        m_prev;
  logic        m_pv;
  int          m_run;
  int          m_miss;
  logic [15:0] m_err_a;
  logic [1:0]  m_err_b;

  // last observed outputs
  logic        obs_locked;
  logic        obs_pulse;
  logic [15:0] obs_err_a;
  logic [1:0]  obs_err_b;
  logic [1:0]  obs_state;

  task automatic model_reset();
    m_state = 2'd0;
    m_prev  = 1'b0;
    m_pv    = 1'b0;
    m_run   = 0;
    m_miss  = 0;
    m_err_a = '0;
    m_err_b = '0;
  endtask

  task automatic model_edge(input logic d, input logic c);
    logic cnt;
    logic g;
    cnt = 1'b0;
    if (!m_pv) begin
      m_pv = 1'b1;
    end else begin
      g = (d != m_prev);
      case (m_state)
        2'd0: begin
          if (g) begin
            m_run++;
            if (m_run == LOCK_N) begin
              m_state = 2'd1;
              m_run   = 0;
              m_miss  = 0;
            end
          end else begin
            m_run = 0;
          end
        end
        2'd1: begin
          if (g) m_miss = 0;
          else begin
            cnt    = 1'b1;
            m_miss = 1;
            m_state = (LOSS_N == 1) ? 2'd0 : 2'd2;
          end
        end
        default: begin
          if (g) begin
            m_state = 2'd1;
            m_miss  = 0;
          end else begin
            cnt = 1'b1;
            m_miss++;
            if (m_miss == LOSS_N) begin
              m_state = 2'd0;
              m_run   = 0;
              m_miss  = 0;
            end
          end
        end
      endcase
    end
    m_prev = d;
    if (cnt) begin
      m_err_a = c ? 16'd1 : ((m_err_a == 16'hFFFF) ? m_err_a : m_err_a + 16'd1);
      m_err_b = c ? 2'd1  : ((m_err_b == 2'd3) ? m_err_b : m_err_b + 2'd1);
    end else if (c) begin
      m_err_a = '0;
      m_err_b = '0;
    end
    exp_q.push_back({(m_state != 2'd0), cnt, m_err_a, m_err_b, m_state});
  endtask

  // ---------------- driver ----------------
  // One clock edge: drive at negedge, push expectation, sample 1 ns after posedge.
  task automatic drive_cycle(input logic d, input logic c);
    logic [EXP_W-1:0] exp_v;
    logic [EXP_W-1:0] act_v;
    @(negedge clk);
    din     = d;
    clr_err = c;
    model_edge(d, c);
    @(posedge clk);
    #1;
    obs_locked = bus_a.locked;
    obs_pulse  = bus_a.err_pulse;
    obs_err_a  = bus_a.err_count;
    obs_err_b  = bus_b.err_count;
    obs_state  = state_a;
    act_v = {obs_locked, obs_pulse, obs_err_a, obs_err_b, obs_state};
    clr_err = 1'b0;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %h with no expectation queued", act_v);
    end else begin
      exp_v = exp_q.pop_front();
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL scoreboard {locked,pulse,err_a,err_b,state}: got %h expected %h at %0t",
                 act_v, exp_v, $time);
      end
    end
  endtask

  task automatic good_toggle();
    drive_cycle(~m_prev, 1'b0);
  endtask

  task automatic slip_then_recover();
    drive_cycle(m_prev, 1'b0);
    repeat (3) good_toggle();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1 reset = 1'b1;
    #2;
    checks++;
    if (bus_a.locked !== 1'b0 || bus_a.err_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: locked=%b pulse=%b, required 0 0", bus_a.locked, bus_a.err_pulse);
    end
    checks++;
    if (bus_a.err_count !== 16'd0 || bus_b.err_count !== 2'd0) begin
      errors++;
      $display("FAIL reset_count: err_a=%0d err_b=%0d, required 0 0", bus_a.err_count, bus_b.err_count);
    end
    checks++;
    if (state_a !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d required 0", state_a);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  task automatic test_perfect_stream();
    for (int i = 1; i <= 100; i++) begin
      drive_cycle(logic'((i - 1) % 2), 1'b0);
      if (i == 4) begin
        checks++;
        if (obs_locked !== 1'b0) begin
          errors++;
          $display("FAIL perfect_lock_early: locked=%b after edge 4, required 0", obs_locked);
        end
      end
      if (i == 5) begin
        checks++;
        if (obs_locked !== 1'b1) begin
          errors++;
          $display("FAIL perfect_lock: locked=%b after edge 5, required 1", obs_locked);
        end
      end
    end
    checks++;
    if (obs_err_a !== 16'd0) begin
      errors++;
      $display("FAIL perfect_errs: err_count=%0d required 0", obs_err_a);
    end
  endtask

  task automatic test_single_slip();
    drive_cycle(m_prev, 1'b0);
    checks++;
    if (obs_pulse !== 1'b1 || obs_err_a !== 16'd1 || obs_state !== 2'd2 || obs_locked !== 1'b1) begin
      errors++;
      $display("FAIL single_slip: pulse=%b err=%0d state=%0d locked=%b, required 1 1 2 1",
               obs_pulse, obs_err_a, obs_state, obs_locked);
    end
    good_toggle();
    checks++;
    if (obs_pulse !== 1'b0 || obs_state !== 2'd1 || obs_locked !== 1'b1 || obs_err_a !== 16'd1) begin
      errors++;
      $display("FAIL slip_recover: pulse=%b state=%0d locked=%b err=%0d, required 0 1 1 1",
               obs_pulse, obs_state, obs_locked, obs_err_a);
    end
    repeat (3) good_toggle();
  endtask

  task automatic test_lock_loss();
    drive_cycle(~m_prev, 1'b1);
    checks++;
    if (obs_err_a !== 16'd0 || obs_pulse !== 1'b0) begin
      errors++;
      $display("FAIL clr_before_loss: err=%0d pulse=%b, required 0 0", obs_err_a, obs_pulse);
    end
    if (m_prev == 1'b0) good_toggle();
    drive_cycle(1'b1, 1'b0);
    checks++;
    if (obs_pulse !== 1'b1 || obs_err_a !== 16'd1 || obs_locked !== 1'b1) begin
      errors++;
      $display("FAIL loss_first: pulse=%b err=%0d locked=%b, required 1 1 1", obs_pulse, obs_err_a, obs_locked);
    end
    drive_cycle(1'b1, 1'b0);
    checks++;
    if (obs_pulse !== 1'b1 || obs_err_a !== 16'd2 || obs_locked !== 1'b0) begin
      errors++;
      $display("FAIL loss_second: pulse=%b err=%0d locked=%b, required 1 2 0", obs_pulse, obs_err_a, obs_locked);
    end
    drive_cycle(1'b1, 1'b0);
    checks++;
    if (obs_pulse !== 1'b0 || obs_err_a !== 16'd2) begin
      errors++;
      $display("FAIL loss_third: pulse=%b err=%0d, required 0 2", obs_pulse, obs_err_a);
    end
    for (int i = 1; i <= 4; i++) begin
      good_toggle();
      if (i == 3) begin
        checks++;
        if (obs_locked !== 1'b0) begin
          errors++;
          $display("FAIL relock_early: locked=%b after 3 good, required 0", obs_locked);
        end
      end
    end
    checks++;
    if (obs_locked !== 1'b1) begin
      errors++;
      $display("FAIL relock: locked=%b after 4 good, required 1", obs_locked);
    end
  endtask

  task automatic test_saturation();
    int pulses;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      drive_cycle(m_prev, 1'b0);
      if (obs_pulse === 1'b1) pulses++;
      for (int j = 0; j < 3; j++) begin
        good_toggle();
        if (obs_pulse === 1'b1) pulses++;
      end
    end
    checks++;
    if (pulses != 6) begin
      errors++;
      $display("FAIL sat_pulses: got %0d pulses, required 6", pulses);
    end
    checks++;
    if (obs_err_b !== 2'd3) begin
      errors++;
      $display("FAIL sat_count: ERR_W=2 count=%0d, required 3", obs_err_b);
    end
    checks++;
    if (obs_err_a !== 16'd8) begin
      errors++;
      $display("FAIL wide_count: count=%0d, required 8", obs_err_a);
    end
  endtask

  task automatic test_clr_err();
    repeat (5) slip_then_recover();
    checks++;
    if (obs_err_a !== 16'd13) begin
      errors++;
      $display("FAIL clr_setup: err=%0d, required 13", obs_err_a);
    end
    drive_cycle(~m_prev, 1'b1);
    repeat (5) slip_then_recover();
    checks++;
    if (obs_err_a !== 16'd5) begin
      errors++;
      $display("FAIL clr_count5: err=%0d, required 5", obs_err_a);
    end
    drive_cycle(~m_prev, 1'b1);
    checks++;
    if (obs_err_a !== 16'd0 || obs_pulse !== 1'b0 || obs_locked !== 1'b1) begin
      errors++;
      $display("FAIL clr_alone: err=%0d pulse=%b locked=%b, required 0 0 1", obs_err_a, obs_pulse, obs_locked);
    end
    drive_cycle(m_prev, 1'b1);
    checks++;
    if (obs_err_a !== 16'd1 || obs_pulse !== 1'b1 || obs_err_b !== 2'd1) begin
      errors++;
      $display("FAIL clr_with_err: err=%0d pulse=%b err_b=%0d, required 1 1 1", obs_err_a, obs_pulse, obs_err_b);
    end
    repeat (3) good_toggle();
  endtask

  task automatic test_mid_reset();
    slip_then_recover();
    checks++;
    if (obs_err_a !== 16'd2 || obs_locked !== 1'b1) begin
      errors++;
      $display("FAIL mid_setup: err=%0d locked=%b, required 2 1", obs_err_a, obs_locked);
    end
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus_a.locked !== 1'b0 || bus_a.err_count !== 16'd0 || bus_b.err_count !== 2'd0 || state_a !== 2'd0) begin
      errors++;
      $display("FAIL mid_reset: locked=%b err=%0d err_b=%0d state=%0d, required 0 0 0 0",
               bus_a.locked, bus_a.err_count, bus_b.err_count, state_a);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    for (int i = 1; i <= 8; i++) begin
      drive_cycle(logic'(i % 2), 1'b0);
      if (i == 5) begin
        checks++;
        if (obs_locked !== 1'b1) begin
          errors++;
          $display("FAIL mid_relock: locked=%b after edge 5, required 1", obs_locked);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic d;
    logic c;
    for (int i = 0; i < 300; i++) begin
      if (i >= 100 && i < 110) d = m_prev;
      else d = ($urandom_range(0, 4) != 0) ? ~m_prev : m_prev;
      c = ($urandom_range(0, 19) == 0);
      drive_cycle(d, c);
    end
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    model_reset();
    test_reset();
    test_perfect_stream();
    test_single_slip();
    test_lock_loss();
    test_saturation();
    test_clr_err();
    test_mid_reset();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within 200000 time units");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/toggle_pattern_checker.md
# toggle_pattern_checker

Receive-side checker for the alternating 0/1 square-wave pattern our two-state toggle generator drives. It samples a single-bit line every clock and locks when it sees a run of correct toggles. Once locked, it flags and counts every missed toggle and drops lock after repeated misses. It sits at the far end of a generator-to-checker link and serves as a bring-up and self-test monitor.

## Interface
Parameters:
- LOCK_COUNT, 4: consecutive good toggles required to declare lock (≥1).
- LOSS_COUNT, 2: consecutive bad toggles that drop lock (≥1).
- ERR_W, 16: width of the saturating error counter.

Ports:
- clk  input  1  single clock; all logic rising-edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- din  input  1  line from the toggle generator, synchronous to clk.
- clr_err  input  1  synchronous one-cycle pulse; clears err_count.
- locked  output  1  high in LOCKED and SLIP.
- err_pulse  output  1  one-cycle strobe per counted error.
- err_count  output  ERR_W  saturating count of errors since reset or the last clr_err.

## Operation
- A prev register holds the last din sample. A prev_valid flag is 0 after reset and becomes 1 on the first edge.
- A comparison is made on every edge where prev_valid=1:
  - good: din != prev.
  - bad: din == prev.
- On the first edge after reset, prev is loaded and no comparison is made.
- State machine, written as three processes (state register, next-state logic, output logic):
  - HUNT (reset state):
    - good: run_cnt+1. When the increment reaches LOCK_COUNT, go to LOCKED.
    - bad: run_cnt=0.
    - No errors are counted in HUNT.
  - LOCKED:
    - good: stay, miss_cnt=0.
    - bad: count an error and set miss_cnt=1. Go to HUNT if LOSS_COUNT==1, otherwise go to SLIP.
  - SLIP:
    - good: go to LOCKED, miss_cnt=0.
    - bad: count an error, miss_cnt+1. When the increment reaches LOSS_COUNT, go to HUNT.
  - Entering HUNT clears run_cnt and miss_cnt. prev is retained.
- Counting an error means:
  - err_pulse=1 for exactly that cycle.
  - err_count increments, saturating at 2^ERR_W−1 (no wrap).
- clr_err:
  - clr_err alone sets err_count=0.
  - clr_err in the same cycle as an error sets err_count=1 and err_pulse=1.
  - clr_err has no effect on the state machine.
- Run and miss counters are clog2-sized to hold LOCK_COUNT and LOSS_COUNT without overflow.

## Timing
- All outputs are registered. They reflect the comparison made on the same edge that samples din, so visible latency is 0 cycles after the sampling edge.
- Reset values: locked=0, err_pulse=0, err_count=0, state=HUNT, prev_valid=0, run_cnt=0, miss_cnt=0.
- Reset takes effect asynchronously mid-operation. Release resumes at the "first edge" behaviour.
- With a perfect stream after reset release and LOCK_COUNT=4:
  - Comparisons occur at edges 2–5.
  - locked rises after edge 5.
- locked falls on the same edge as the LOSS_COUNT-th consecutive error.
- A good toggle in SLIP restores LOCKED with no change on locked.
- err_pulse is never high for two edges unless two bad comparisons occur back to back.

## Structure
- Shared package holds:
  - state encoding localparams HUNT=2'd0, LOCKED=2'd1, SLIP=2'd2;
  - defaults for LOCK_COUNT, LOSS_COUNT and ERR_W.
- One sub-module: sat_counter. It is a parameterised-width saturating up-counter with synchronous clear and increment, where increment wins on a same-cycle clear by loading 1. It is used for err_count.
- The top module contains the FSM, the prev/prev_valid registers and the run/miss counters.

## Test plan
- Perfect stream: reset, then din=0,1,0,1,… from edge 1.
  - locked=1 after edge 5; err_count stays 0 for 100 cycles.
- Single slip while locked: din …0,1,1,0,1….
  - One err_pulse, err_count=1.
  - State goes SLIP, then back to LOCKED.
  - locked stays 1 throughout.
- Lock loss: stuck-at-1 for 3 samples while locked (LOSS_COUNT=2).
  - Two err_pulses, err_count=2; locked=0 on the second error.
  - Third bad sample is not counted.
  - Relock 4 good toggles later.
- Saturation: ERR_W=2, 6 isolated single slips while locked.
  - err_count sticks at 3; err_pulse still fires 6 times.
- clr_err:
  - With err_count=5, pulse clr_err alone: err_count=0.
  - Pulse clr_err together with a bad toggle: err_count=1, err_pulse=1.
- Mid-operation reset: assert reset asynchronously while locked with err_count=2.
  - locked=0 and err_count=0 without waiting for a clock edge.
  - After release with a perfect stream, locked=1 after edge 5.
